// File: rtl/echo_pkg.sv
// Shared types, default offsets and the signed clip helper for the echo stage.
package echo_pkg;

  typedef enum logic [2:0] {IDLE, READ, WAIT, CALC, WRITE} state_t;

  localparam int ADC_OFFSET_D = 385;
  localparam int DAC_OFFSET_D = 512;

  // Clip a signed 12-bit value into the signed 10-bit range [-512, 511].
  function automatic logic signed [9:0] sat10(input logic signed [11:0] v);
    if (v > 12'sd511)       return 10'sd511;
    else if (v < -12'sd512) return -10'sd512;
    else                    return v[9:0];
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Single-port sample buffer with registered read data (read-first), maps to block RAM.
module sample_ram #(
  parameter int ADDR_W = 13
) (
  input  logic              sysclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [9:0]        wdata,
  output logic [9:0]        rdata
);

  logic [9:0] mem [0:(1<<ADDR_W)-1];

  // Write when enabled; read data is always the pre-write contents one cycle later.
  always_ff @(posedge sysclk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/echo_proc.sv
// Single-echo stage: offset removal, delayed attenuated echo from a circular buffer,
// saturation and re-offset to DAC mid-scale. One sample every 5 cycles at most.
module echo_proc
  import echo_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int DELAY      = 5000,
  parameter int SHIFT      = 1,
  parameter int ADC_OFFSET = ADC_OFFSET_D,
  parameter int DAC_OFFSET = DAC_OFFSET_D
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic [9:0] data_in,
  output logic [9:0] data_out,
  output logic       out_valid
);

  localparam logic [ADDR_W-1:0] DLY   = ADDR_W'(DELAY);
  localparam logic signed [11:0] ADC_S = 12'(ADC_OFFSET);
  localparam logic [9:0]         DAC_U = 10'(DAC_OFFSET);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  fill_q, fill_d;
  logic signed [9:0]  x_q, x_d;
  logic signed [9:0]  y_q, y_d;
  logic [9:0]         dout_q, dout_d;
  logic               ov_q, ov_d;

  logic [ADDR_W-1:0]  rd_addr, ram_addr;
  logic               ram_we;
  logic [9:0]         ram_rdata;
  logic signed [11:0] adc_diff, rd_ext, echo, x_ext, sum;
  logic [9:0]         y_u;

  // Read pointer trails the write pointer by DELAY; the write slot is only addressed in WRITE.
  assign rd_addr  = wr_ptr_q - DLY;
  assign ram_we   = (state_q == WRITE);
  assign ram_addr = ram_we ? wr_ptr_q : rd_addr;

  assign adc_diff = $signed({2'b00, data_in}) - ADC_S;
  assign rd_ext   = {{2{ram_rdata[9]}}, ram_rdata};
  // Until DELAY samples have been written the read slot is stale, so the echo is masked.
  assign echo     = (fill_q == DLY) ? (rd_ext >>> SHIFT) : 12'sd0;
  assign x_ext    = {{2{x_q[9]}}, x_q};
  assign sum      = x_ext + echo;
  assign y_u      = y_q;

  sample_ram #(.ADDR_W(ADDR_W)) u_ram (
    .sysclk (sysclk),
    .we     (ram_we),
    .addr   (ram_addr),
    .wdata  (x_q),
    .rdata  (ram_rdata)
  );

  // State and datapath registers; reset drops any in-flight sample.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      dout_q   <= DAC_U;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dout_q   <= dout_d;
      ov_q     <= ov_d;
    end
  end

  // Next-state and datapath updates; data_valid is only looked at in IDLE.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    x_d      = x_q;
    y_d      = y_q;
    dout_d   = dout_q;
    ov_d     = 1'b0;
    case (state_q)
      IDLE: if (data_valid) begin
        x_d     = sat10(adc_diff);
        state_d = READ;
      end
      READ:  state_d = WAIT;
      WAIT:  state_d = CALC;
      CALC: begin
        y_d     = sat10(sum);
        state_d = WRITE;
      end
      WRITE: begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (fill_q != DLY) fill_d = fill_q + ADDR_W'(1);
        dout_d  = y_u + DAC_U;
        ov_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out  = dout_q;
  assign out_valid = ov_q;

endmodule
